// File: rtl/hazard_sequencer.sv
// Hazard, stall and forwarding controller for the five-stage pipeline.
// Owns the multi-cycle multiply hold FSM and a saturating stall-cycle counter.

module hazard_fwd_match (
   input  logic [4:0] src,
   input  logic [4:0] dst,
   input  logic       wen,
   output logic       hit
);
   // r0 is hardwired zero, so a write targeting it never forwards
   assign hit = wen && (src != 5'd0) && (src == dst);
endmodule

module hazard_sequencer #(
   parameter int MUL_CYCLES = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             MulStartE,
   input  logic             MemAccessM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             MulDoneE,
   output logic [CNT_W-1:0] StallCount
);

   localparam int CW = (MUL_CYCLES > 3) ? $clog2(MUL_CYCLES - 2) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

   mul_state_t      state;
   logic [CW-1:0]   cnt;
   logic            mul_done;

   // Operand index 0 = Rs, 1 = Rt
   logic [1:0][4:0] src_e, src_d;
   logic [1:0]      hit_em, hit_ew, hit_dm;
   logic [1:0][1:0] fwd_e;

   assign src_e = {RtE, RsE};
   assign src_d = {RtD, RsD};

   genvar i;
   generate
      for (i = 0; i < 2; i++) begin : g_fwd
         hazard_fwd_match u_em (.src(src_e[i]), .dst(WriteRegM), .wen(RegWriteM), .hit(hit_em[i]));
         hazard_fwd_match u_ew (.src(src_e[i]), .dst(WriteRegW), .wen(RegWriteW), .hit(hit_ew[i]));
         hazard_fwd_match u_dm (.src(src_d[i]), .dst(WriteRegM), .wen(RegWriteM), .hit(hit_dm[i]));
         // Memory stage is younger than writeback, so it wins
         assign fwd_e[i] = hit_em[i] ? 2'b10 : (hit_ew[i] ? 2'b01 : 2'b00);
      end
   endgenerate

   assign ForwardAE = fwd_e[0];
   assign ForwardBE = fwd_e[1];
   assign ForwardAD = hit_dm[0];
   assign ForwardBD = hit_dm[1];

   logic lwstall, brstall, mem_stall, mul_stall, stall_any, stall_e;

   assign lwstall   = MemtoRegE && ((RsD == RtE) || (RtD == RtE));
   assign brstall   = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
   assign mem_stall = MemAccessM && !MemReadyM;
   assign mul_stall = (state == BUSY) || ((state == IDLE) && MulStartE);

   assign stall_any = lwstall | brstall | mul_stall | mem_stall;
   assign stall_e   = mul_stall | mem_stall;

   // Reset holds no register but bubbles Execute and Writeback
   assign StallF = stall_any & ~reset;
   assign StallD = stall_any & ~reset;
   assign StallE = stall_e & ~reset;
   assign StallM = mem_stall & ~reset;
   assign FlushW = mem_stall | reset;
   assign FlushE = ((lwstall | brstall) & ~stall_e) | reset;
   assign MulDoneE = mul_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         mul_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               mul_done <= 1'b0;
               if (MulStartE) begin
                  cnt   <= CW'(MUL_CYCLES - 3);
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state    <= DONE;
                  mul_done <= 1'b1;
               end else begin
                  cnt      <= cnt - 1'b1;
                  mul_done <= 1'b0;
               end
            end
            DONE: begin
               // Result stays valid while Execute is frozen behind memory
               if (mem_stall) begin
                  mul_done <= 1'b1;
               end else begin
                  state    <= IDLE;
                  mul_done <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               mul_done <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         StallCount <= '0;
      else if (StallF && !(&StallCount))
         StallCount <= StallCount + 1'b1;
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: vector table for combinational hazards,
// hand sequences for multiply, memory wait, reset and counter saturation.

module tb_hazard_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
   logic       BranchD, MulStartE, MemAccessM, MemReadyM;
   logic       StallF, StallD, StallE, StallM, FlushE, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, MulDoneE;
   logic [31:0] StallCount;

   logic       s_StallF, s_StallD, s_StallE, s_StallM, s_FlushE, s_FlushW;
   logic [1:0] s_ForwardAE, s_ForwardBE;
   logic       s_ForwardAD, s_ForwardBD, s_MulDoneE;
   logic [3:0] s_StallCount;

   hazard_sequencer #(.MUL_CYCLES(4), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MulStartE(MulStartE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD), .MulDoneE(MulDoneE),
      .StallCount(StallCount)
   );

   hazard_sequencer #(.MUL_CYCLES(4), .CNT_W(4)) dut_sat (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM), .BranchD(BranchD),
      .MulStartE(MulStartE), .MemAccessM(MemAccessM), .MemReadyM(MemReadyM),
      .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE), .StallM(s_StallM),
      .FlushE(s_FlushE), .FlushW(s_FlushW), .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
      .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD), .MulDoneE(s_MulDoneE),
      .StallCount(s_StallCount)
   );

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   typedef struct {
      string      nm;
      logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
      logic [2:0] rw;   // {E,M,W}
      logic [1:0] m2r;  // {E,M}
      logic       br, ma, mr;
      logic [1:0] fae, fbe;
      logic       fad, fbd, stl, stle, stlm, fle, flw;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic clr();
      RsD = 0; RtD = 0; RsE = 0; RtE = 0; WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; MemtoRegM = 0;
      BranchD = 0; MulStartE = 0; MemAccessM = 0; MemReadyM = 1;
   endtask

   task automatic nxt();
      @(posedge clk); #1;
   endtask

   // Checks the multiply-visible outputs of one cycle and models the counter
   task automatic chk_cyc(input string nm, input logic se, input logic md, input logic sf);
      #1;
      chk({nm, "_stalle"}, StallE, se);
      chk({nm, "_muldone"}, MulDoneE, md);
      chk({nm, "_stallf"}, StallF, sf);
      if (sf) exp_cnt++;
   endtask

   initial begin
      //          nm         rsd rtd rse rte wre wrm wrw rw      m2r    br ma mr fae fbe fad fbd stl stle stlm fle flw
      vecs[0]  = '{"idle",     0,  0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 0, 0, 1, 0,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[1]  = '{"fwdAE_M",  0,  0,  5,  0,  0,  5,  0, 3'b010, 2'b00, 0, 0, 1, 2,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[2]  = '{"fwdAE_W",  0,  0,  5,  0,  0,  5,  5, 3'b001, 2'b00, 0, 0, 1, 1,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[3]  = '{"fwd_prio", 0,  0,  5,  5,  0,  5,  5, 3'b011, 2'b00, 0, 0, 1, 2,  2,  0,  0,  0,  0,   0,   0,  0};
      vecs[4]  = '{"fwd_r0",   0,  0,  0,  0,  0,  0,  0, 3'b011, 2'b00, 0, 0, 1, 0,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[5]  = '{"fwdBE_W",  0,  0,  3,  7,  0,  2,  7, 3'b011, 2'b00, 0, 0, 1, 0,  1,  0,  0,  0,  0,   0,   0,  0};
      vecs[6]  = '{"fwdD",     9,  9,  0,  0,  0,  9,  0, 3'b010, 2'b00, 0, 0, 1, 0,  0,  1,  1,  0,  0,   0,   0,  0};
      vecs[7]  = '{"lw_rs",    3,  0,  0,  3,  0,  0,  0, 3'b000, 2'b10, 0, 0, 1, 0,  0,  0,  0,  1,  0,   0,   1,  0};
      vecs[8]  = '{"lw_rt",    1,  4,  0,  4,  0,  0,  0, 3'b000, 2'b10, 0, 0, 1, 0,  0,  0,  0,  1,  0,   0,   1,  0};
      vecs[9]  = '{"lw_none",  1,  2,  0,  4,  0,  0,  0, 3'b000, 2'b10, 0, 0, 1, 0,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[10] = '{"br_E",     6,  0,  0,  0,  6,  0,  0, 3'b100, 2'b00, 1, 0, 1, 0,  0,  0,  0,  1,  0,   0,   1,  0};
      vecs[11] = '{"br_M",     1,  8,  0,  0,  0,  8,  0, 3'b000, 2'b01, 1, 0, 1, 0,  0,  0,  0,  1,  0,   0,   1,  0};
      vecs[12] = '{"br_none",  1,  2,  0,  0,  3,  4,  0, 3'b110, 2'b01, 1, 0, 1, 0,  0,  0,  0,  0,  0,   0,   0,  0};
      vecs[13] = '{"mem",      0,  0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 0, 1, 0, 0,  0,  0,  0,  1,  1,   1,   0,  1};
      vecs[14] = '{"mem_lw",   3,  0,  0,  3,  0,  0,  0, 3'b000, 2'b10, 0, 1, 0, 0,  0,  0,  0,  1,  1,   1,   0,  1};
      vecs[15] = '{"mem_rdy",  0,  0,  0,  0,  0,  0,  0, 3'b000, 2'b00, 0, 1, 1, 0,  0,  0,  0,  0,  0,   0,   0,  0};

      // Reset with hazards present: no stalls, both flushes forced
      clr(); reset = 1;
      MemAccessM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 3; RsD = 3;
      nxt(); nxt(); #1;
      chk("rst_stallf", StallF, 0);
      chk("rst_stalld", StallD, 0);
      chk("rst_stalle", StallE, 0);
      chk("rst_stallm", StallM, 0);
      chk("rst_flushe", FlushE, 1);
      chk("rst_flushw", FlushW, 1);
      chk("rst_count", StallCount, 0);
      chk("rst_muldone", MulDoneE, 0);
      nxt(); reset = 0; clr(); exp_cnt = 0;

      for (int i = 0; i < 16; i++) begin
         nxt();
         RsD = vecs[i].rsd; RtD = vecs[i].rtd; RsE = vecs[i].rse; RtE = vecs[i].rte;
         WriteRegE = vecs[i].wre; WriteRegM = vecs[i].wrm; WriteRegW = vecs[i].wrw;
         {RegWriteE, RegWriteM, RegWriteW} = vecs[i].rw;
         {MemtoRegE, MemtoRegM} = vecs[i].m2r;
         BranchD = vecs[i].br; MemAccessM = vecs[i].ma; MemReadyM = vecs[i].mr;
         MulStartE = 0;
         #1;
         chk({vecs[i].nm, "_fae"}, ForwardAE, vecs[i].fae);
         chk({vecs[i].nm, "_fbe"}, ForwardBE, vecs[i].fbe);
         chk({vecs[i].nm, "_fad"}, ForwardAD, vecs[i].fad);
         chk({vecs[i].nm, "_fbd"}, ForwardBD, vecs[i].fbd);
         chk({vecs[i].nm, "_stallf"}, StallF, vecs[i].stl);
         chk({vecs[i].nm, "_stalld"}, StallD, vecs[i].stl);
         chk({vecs[i].nm, "_stalle"}, StallE, vecs[i].stle);
         chk({vecs[i].nm, "_stallm"}, StallM, vecs[i].stlm);
         chk({vecs[i].nm, "_flushe"}, FlushE, vecs[i].fle);
         chk({vecs[i].nm, "_flushw"}, FlushW, vecs[i].flw);
         if (vecs[i].stl) exp_cnt++;
      end

      // Load-use for one cycle: one stall, one bubble, counter +1
      nxt(); clr(); MemtoRegE = 1; RtE = 3; RsD = 3; #1;
      chk("lu_stallf", StallF, 1);
      chk("lu_stalld", StallD, 1);
      chk("lu_flushe", FlushE, 1);
      exp_cnt++;
      nxt(); clr(); #1;
      chk("lu_after_stallf", StallF, 0);
      chk("lu_after_flushe", FlushE, 0);
      chk("lu_count", StallCount, exp_cnt);

      // Single multiply: held 3 cycles, done on the 4th, idle on the 5th
      nxt(); MulStartE = 1; chk_cyc("mul_t0", 1, 0, 1);
      nxt(); chk_cyc("mul_t1", 1, 0, 1);
      nxt(); chk_cyc("mul_t2", 1, 0, 1);
      nxt(); chk_cyc("mul_t3", 0, 1, 0);
      nxt(); MulStartE = 0; chk_cyc("mul_t4", 0, 0, 0);
      chk("mul_count", StallCount, exp_cnt);

      // Back-to-back multiplies, second one finishing under a memory stall
      nxt(); MulStartE = 1; chk_cyc("b2b_t0", 1, 0, 1);
      nxt(); chk_cyc("b2b_t1", 1, 0, 1);
      nxt(); chk_cyc("b2b_t2", 1, 0, 1);
      nxt(); chk_cyc("b2b_t3", 0, 1, 0);
      nxt(); chk_cyc("b2b_t4", 1, 0, 1);
      nxt(); chk_cyc("b2b_t5", 1, 0, 1);
      nxt(); chk_cyc("b2b_t6", 1, 0, 1);
      nxt(); MulStartE = 0; MemAccessM = 1; MemReadyM = 0; chk_cyc("b2b_t7", 1, 1, 1);
      nxt(); chk_cyc("b2b_t8", 1, 1, 1);
      nxt(); MemReadyM = 1; chk_cyc("b2b_t9", 0, 1, 0);
      nxt(); clr(); chk_cyc("b2b_t10", 0, 0, 0);
      chk("b2b_count", StallCount, exp_cnt);

      // Memory wait with concurrent load-use: no flush until memory completes
      for (int c = 0; c < 3; c++) begin
         nxt(); clr(); MemAccessM = 1; MemReadyM = 0; MemtoRegE = 1; RtE = 3; RsD = 3; #1;
         chk("mw_stallf", StallF, 1);
         chk("mw_stalle", StallE, 1);
         chk("mw_stallm", StallM, 1);
         chk("mw_flushw", FlushW, 1);
         chk("mw_flushe", FlushE, 0);
         exp_cnt++;
      end
      nxt(); MemReadyM = 1; #1;
      chk("mw_rdy_stallf", StallF, 1);
      chk("mw_rdy_stalle", StallE, 0);
      chk("mw_rdy_flushw", FlushW, 0);
      chk("mw_rdy_flushe", FlushE, 1);
      exp_cnt++;
      nxt(); clr(); #1;
      chk("mw_count", StallCount, exp_cnt);

      // Reset mid-multiply abandons it
      nxt(); MulStartE = 1; chk_cyc("rb_t0", 1, 0, 1);
      nxt(); MulStartE = 0; reset = 1; #1;
      chk("rb_t1_stalle", StallE, 0);
      chk("rb_t1_flushe", FlushE, 1);
      nxt(); reset = 0; exp_cnt = 0; #1;
      chk("rb_t2_stalle", StallE, 0);
      chk("rb_t2_muldone", MulDoneE, 0);
      chk("rb_t2_count", StallCount, 0);
      nxt(); #1;
      chk("rb_t3_muldone", MulDoneE, 0);
      chk("rb_t3_stalle", StallE, 0);

      // 20 stall cycles: 4-bit counter saturates, 32-bit one does not
      for (int c = 0; c < 20; c++) begin
         nxt(); MemAccessM = 1; MemReadyM = 0;
      end
      nxt(); clr(); #1;
      chk("sat_count4", {28'd0, s_StallCount}, 32'd15);
      chk("sat_count32", StallCount, 32'd20);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
